cdb_broadcaster: RTL and testbench
==================================

Name: cdb_broadcaster

Overview:
Producer end of the two common data buses (Arith CDB, LS CDB) that the issue-stage forwarding logic, RS, LSB and ROB snoop. Collects completed results from ALU, BRU (branch unit, link value) and LSU (load data). ALU and BRU share the Arith CDB through round-robin arbitration with per-source buffering; the LSU drives the LS CDB alone. Sits between the execution units and every CDB consumer; all bus outputs are registered.

Parameters:
ROB_ID_WIDTH, 4, width of a ROB tag (matches ROB_ID_TYPE); tag 0 = ZERO_ROB = "no dependency", never a valid producer tag
DATA_WIDTH, 32, result width (DATA_TYPE)
FIFO_DEPTH, 4, entries per ALU/BRU pending buffer (power of 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
rdy  in  1  global ready; 0 freezes all state
flush  in  1  ROB rollback (mispredict): discard everything pending
alu_valid  in  1  ALU result offered
alu_rob_id  in  ROB_ID_WIDTH  ALU result tag
alu_result  in  DATA_WIDTH  ALU result
alu_ready  out  1  ALU result accepted this cycle when alu_valid=1
bru_valid / bru_rob_id / bru_result / bru_ready  same as ALU set, for BRU
lsu_valid  in  1  load result offered
lsu_rob_id  in  ROB_ID_WIDTH  load tag
lsu_result  in  DATA_WIDTH  load data
lsu_ready  out  1  equals rdy
arith_cdb_valid  out  1  Arith CDB broadcast valid
arith_cdb_rob_id  out  ROB_ID_WIDTH  Arith CDB tag
arith_cdb_result  out  DATA_WIDTH  Arith CDB value
ls_cdb_valid / ls_cdb_rob_id / ls_cdb_result  out  1/ROB_ID_WIDTH/DATA_WIDTH  LS CDB

Behaviour:
- Priority per edge: rst=0 > flush=1 > rdy=0 > normal operation.
- Reset/flush: FIFOs empty, all *_cdb_valid/rob_id/result = 0, last_grant = BRU (so ALU wins the first conflict). Inputs presented in the same cycle are dropped.
- rdy=0: no push, no pop, outputs hold previous values; alu_ready=bru_ready=lsu_ready=0.
- alu_ready = rdy && (alu_count < FIFO_DEPTH). Purely count-based: a full FIFO does not accept even if it pops in the same cycle. BRU is identical.
- Accept: valid && ready && rob_id != 0. Offers with rob_id 0 are silently dropped and never broadcast.
- Candidate per source: FIFO head if non-empty; otherwise the accepted input this cycle (bypass). Bypass is only legal when the FIFO is empty, so per-source order is preserved.
- Arith arbitration:
  - One candidate: it wins.
  - Two candidates: the source not equal to last_grant wins; last_grant updates to the winner.
  - Winner's head is popped, or its bypassed input is consumed without enqueue.
  - A loser's accepted input is enqueued.
- Arith output regs load the winner with valid=1; if there is no candidate, valid=0. Every broadcast is a single-cycle pulse per result.
- LS path: an accepted LSU input is registered to the LS CDB the next cycle (valid=1 for one cycle); otherwise valid=0.
- Latency: a result accepted in cycle N with an empty FIFO and an uncontested bus appears on the CDB in cycle N+1. rob_id/result are don't-care when valid=0 but must stay registered (no combinational path from inputs to the CDB).
- Simultaneous push and pop on one FIFO: count unchanged, pointers wrap modulo FIFO_DEPTH.
- Invariant: no result is lost or duplicated; every accepted tag is broadcast exactly once unless flushed.

Decomposition:
- Shared constant header: ROB_ID_TYPE, DATA_TYPE, ZERO_ROB, TRUE/FALSE. No new package.
- One sub-module, cdb_fifo: parameterized sync FIFO with push/pop/head/count, flush and active-low sync reset. Instantiated for ALU and BRU.
- Arbiter and output registers live in cdb_broadcaster.

Test Plan:
- ALU id 5, 0xDEADBEEF in cycle N, all else idle -> arith_cdb_valid=1, id 5, 0xDEADBEEF in cycle N+1 only; cycle N+2 valid=0.
- ALU id 3 and BRU id 4 in the same cycle N after reset -> cycle N+1 id 3, N+2 id 4; bru_ready stays 1.
- ALU and BRU offer new tags every cycle (ALU 1..7, BRU 8..14) -> broadcasts alternate; each *_ready drops when its count reaches 4; every tag appears exactly once, per-source order kept.
- Two entries pending in each FIFO, flush=1 in cycle N -> cycle N+1 both CDB valids 0, readies 1; nothing pending is ever broadcast; new ALU id 2 in N+1 broadcasts in N+2.
- rdy=0 for 3 cycles mid-burst -> CDB outputs frozen, readies 0; after rdy=1 the sequence resumes with no loss or duplication.
- LSU id 0 offered -> no broadcast. LSU id 9 in cycle N together with rst=0 in cycle N+1 -> all outputs 0 from N+2; id 9 never broadcast after reset.

Source files
------------

// File: rtl/cdb_broadcaster_pkg.sv
// Shared CDB constants and types.
//   ROB_ID_W_DEF / DATA_W_DEF : default tag and result widths
//   ROB_ID_TYPE / DATA_TYPE   : tag and result types at the default widths
//   ZERO_ROB                  : reserved "no dependency" tag, never a producer tag
//   TRUE / FALSE              : single-bit constants
//   cdb_src_e                 : Arith CDB source identifiers for arbitration
package cdb_broadcaster_pkg;

    localparam int unsigned ROB_ID_W_DEF = 4;
    localparam int unsigned DATA_W_DEF   = 32;

    typedef logic [ROB_ID_W_DEF-1:0] ROB_ID_TYPE;
    typedef logic [DATA_W_DEF-1:0]   DATA_TYPE;

    localparam int unsigned ZERO_ROB = 0;
    localparam logic        TRUE     = 1'b1;
    localparam logic        FALSE    = 1'b0;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_BRU = 1'b1
    } cdb_src_e;

endpackage

// File: rtl/cdb_broadcaster_fifo.sv
// Synchronous pending-result FIFO for one Arith CDB source.
// Ports:
//   clk_i    : clock
//   rst_ni   : synchronous reset, active-low (empties the FIFO)
//   flush_i  : synchronous discard of all entries
//   push_i   : write data_i at the tail (caller guarantees not full)
//   data_i   : entry to write
//   pop_i    : drop the head entry (caller guarantees not empty)
//   head_o   : current head entry
//   count_o  : number of stored entries (0..DEPTH)
//   empty_o  : count_o == 0
module cdb_fifo #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // DEPTH is a power of two, so pointer wrap is plain binary overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/cdb_broadcaster.sv
// Producer end of the Arith CDB (ALU + BRU, round-robin shared) and the
// LS CDB (LSU only). All bus outputs are registered.
// Ports:
//   clk, rst (sync, active-low), rdy (0 freezes state), flush (discard pending)
//   alu_* / bru_* : valid/rob_id/result offer, ready = accepted when valid
//   lsu_*         : load result offer, lsu_ready = rdy
//   arith_cdb_*   : Arith CDB broadcast (valid/rob_id/result)
//   ls_cdb_*      : LS CDB broadcast (valid/rob_id/result)
module cdb_broadcaster
    import cdb_broadcaster_pkg::*;
#(
    parameter int unsigned ROB_ID_WIDTH = ROB_ID_W_DEF,
    parameter int unsigned DATA_WIDTH   = DATA_W_DEF,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    flush,
    input  logic                    alu_valid,
    input  logic [ROB_ID_WIDTH-1:0] alu_rob_id,
    input  logic [DATA_WIDTH-1:0]   alu_result,
    output logic                    alu_ready,
    input  logic                    bru_valid,
    input  logic [ROB_ID_WIDTH-1:0] bru_rob_id,
    input  logic [DATA_WIDTH-1:0]   bru_result,
    output logic                    bru_ready,
    input  logic                    lsu_valid,
    input  logic [ROB_ID_WIDTH-1:0] lsu_rob_id,
    input  logic [DATA_WIDTH-1:0]   lsu_result,
    output logic                    lsu_ready,
    output logic                    arith_cdb_valid,
    output logic [ROB_ID_WIDTH-1:0] arith_cdb_rob_id,
    output logic [DATA_WIDTH-1:0]   arith_cdb_result,
    output logic                    ls_cdb_valid,
    output logic [ROB_ID_WIDTH-1:0] ls_cdb_rob_id,
    output logic [DATA_WIDTH-1:0]   ls_cdb_result
);

    localparam int unsigned ENT_W = ROB_ID_WIDTH + DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [ROB_ID_WIDTH-1:0] NO_TAG = ROB_ID_WIDTH'(ZERO_ROB);

    logic [ENT_W-1:0] alu_head, bru_head;
    logic [CNT_W-1:0] alu_count, bru_count;
    logic             alu_empty, bru_empty;

    logic             run;
    logic             alu_acc, bru_acc, lsu_acc;
    logic             alu_cand, bru_cand, any_cand;
    logic [ENT_W-1:0] alu_cand_data, bru_cand_data, win_data;
    logic             alu_win, bru_win;
    logic             alu_push, bru_push, alu_pop, bru_pop;
    cdb_src_e         grant;
    cdb_src_e         last_grant_q, last_grant_d;

    logic                    arith_valid_q;
    logic [ROB_ID_WIDTH-1:0] arith_id_q;
    logic [DATA_WIDTH-1:0]   arith_res_q;
    logic                    ls_valid_q;
    logic [ROB_ID_WIDTH-1:0] ls_id_q;
    logic [DATA_WIDTH-1:0]   ls_res_q;

    always_comb begin
        run       = rst && !flush && rdy;
        // Count-based only: a full FIFO refuses even when it pops this cycle.
        alu_ready = rdy && (alu_count < CNT_W'(FIFO_DEPTH));
        bru_ready = rdy && (bru_count < CNT_W'(FIFO_DEPTH));
        lsu_ready = rdy;

        alu_acc = run && alu_valid && alu_ready && (alu_rob_id != NO_TAG);
        bru_acc = run && bru_valid && bru_ready && (bru_rob_id != NO_TAG);
        lsu_acc = run && lsu_valid && (lsu_rob_id != NO_TAG);

        // Bypass the input only when nothing older is queued for that source.
        alu_cand      = !alu_empty || alu_acc;
        bru_cand      = !bru_empty || bru_acc;
        alu_cand_data = alu_empty ? {alu_rob_id, alu_result} : alu_head;
        bru_cand_data = bru_empty ? {bru_rob_id, bru_result} : bru_head;
        any_cand      = alu_cand || bru_cand;

        grant        = SRC_ALU;
        last_grant_d = last_grant_q;
        if (alu_cand && bru_cand) begin
            grant        = (last_grant_q == SRC_ALU) ? SRC_BRU : SRC_ALU;
            last_grant_d = grant;
        end else if (bru_cand) begin
            grant = SRC_BRU;
        end

        alu_win  = alu_cand && (grant == SRC_ALU);
        bru_win  = bru_cand && (grant == SRC_BRU);
        win_data = (grant == SRC_ALU) ? alu_cand_data : bru_cand_data;

        alu_pop  = run && alu_win && !alu_empty;
        bru_pop  = run && bru_win && !bru_empty;
        // A winning bypass is consumed directly; every other accept is queued.
        alu_push = alu_acc && !(alu_win && alu_empty);
        bru_push = bru_acc && !(bru_win && bru_empty);
    end

    cdb_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_alu_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .flush_i (flush),
        .push_i  (alu_push),
        .data_i  ({alu_rob_id, alu_result}),
        .pop_i   (alu_pop),
        .head_o  (alu_head),
        .count_o (alu_count),
        .empty_o (alu_empty)
    );

    cdb_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_bru_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .flush_i (flush),
        .push_i  (bru_push),
        .data_i  ({bru_rob_id, bru_result}),
        .pop_i   (bru_pop),
        .head_o  (bru_head),
        .count_o (bru_count),
        .empty_o (bru_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            last_grant_q  <= SRC_BRU;
            arith_valid_q <= FALSE;
            arith_id_q    <= '0;
            arith_res_q   <= '0;
            ls_valid_q    <= FALSE;
            ls_id_q       <= '0;
            ls_res_q      <= '0;
        end else if (rdy) begin
            last_grant_q  <= last_grant_d;
            arith_valid_q <= any_cand;
            if (any_cand) begin
                {arith_id_q, arith_res_q} <= win_data;
            end
            ls_valid_q <= lsu_acc;
            if (lsu_acc) begin
                ls_id_q  <= lsu_rob_id;
                ls_res_q <= lsu_result;
            end
        end
    end

    assign arith_cdb_valid  = arith_valid_q;
    assign arith_cdb_rob_id = arith_id_q;
    assign arith_cdb_result = arith_res_q;
    assign ls_cdb_valid     = ls_valid_q;
    assign ls_cdb_rob_id    = ls_id_q;
    assign ls_cdb_result    = ls_res_q;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Self-checking bench for cdb_broadcaster: queue-based reference model,
// per-cycle compare process, directed scenarios with literal expectations.
module tb_cdb_broadcaster;

    localparam int RW = 4;
    localparam int DW = 32;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst, rdy, flush;
    logic          alu_valid, bru_valid, lsu_valid;
    logic [RW-1:0] alu_rob_id, bru_rob_id, lsu_rob_id;
    logic [DW-1:0] alu_result, bru_result, lsu_result;
    logic          alu_ready, bru_ready, lsu_ready;
    logic          arith_cdb_valid, ls_cdb_valid;
    logic [RW-1:0] arith_cdb_rob_id, ls_cdb_rob_id;
    logic [DW-1:0] arith_cdb_result, ls_cdb_result;

    always #5 clk = ~clk;

    cdb_broadcaster #(
        .ROB_ID_WIDTH (RW),
        .DATA_WIDTH   (DW),
        .FIFO_DEPTH   (D)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .flush            (flush),
        .alu_valid        (alu_valid),
        .alu_rob_id       (alu_rob_id),
        .alu_result       (alu_result),
        .alu_ready        (alu_ready),
        .bru_valid        (bru_valid),
        .bru_rob_id       (bru_rob_id),
        .bru_result       (bru_result),
        .bru_ready        (bru_ready),
        .lsu_valid        (lsu_valid),
        .lsu_rob_id       (lsu_rob_id),
        .lsu_result       (lsu_result),
        .lsu_ready        (lsu_ready),
        .arith_cdb_valid  (arith_cdb_valid),
        .arith_cdb_rob_id (arith_cdb_rob_id),
        .arith_cdb_result (arith_cdb_result),
        .ls_cdb_valid     (ls_cdb_valid),
        .ls_cdb_rob_id    (ls_cdb_rob_id),
        .ls_cdb_result    (ls_cdb_result)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [RW-1:0] id;
        logic [DW-1:0] data;
    } ent_t;

    ent_t aq[$];
    ent_t bq[$];
    bit   last_was_bru;
    bit   model_live = 0;
    bit   e_new;
    logic e_av, e_lv;
    ent_t e_a, e_l;
    int   seen[16];

    always @(posedge clk) begin : model
        bit a_ok, b_ok, ac, bc, pick_a;
        e_new = 0;
        if (!rst || flush) begin
            aq.delete();
            bq.delete();
            last_was_bru = 1;
            e_av = 0; e_a = '0;
            e_lv = 0; e_l = '0;
            if (!rst) model_live = 1;
        end else if (rdy) begin
            e_new = 1;
            a_ok = alu_valid && (aq.size() < D) && (alu_rob_id != 0);
            b_ok = bru_valid && (bq.size() < D) && (bru_rob_id != 0);
            if (a_ok) aq.push_back({alu_rob_id, alu_result});
            if (b_ok) bq.push_back({bru_rob_id, bru_result});
            ac = aq.size() > 0;
            bc = bq.size() > 0;
            if (ac && bc) begin
                pick_a       = last_was_bru;
                last_was_bru = !pick_a;
            end else begin
                pick_a = ac;
            end
            e_av = ac || bc;
            if (e_av) e_a = pick_a ? aq.pop_front() : bq.pop_front();
            e_lv = lsu_valid && (lsu_rob_id != 0);
            if (e_lv) e_l = {lsu_rob_id, lsu_result};
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            chk("arith_valid", 32'(arith_cdb_valid), 32'(e_av));
            if (e_av) begin
                chk("arith_rob_id", 32'(arith_cdb_rob_id), 32'(e_a.id));
                chk("arith_result", arith_cdb_result, e_a.data);
                if (e_new && arith_cdb_valid === 1'b1) seen[int'(arith_cdb_rob_id)]++;
            end
            chk("ls_valid", 32'(ls_cdb_valid), 32'(e_lv));
            if (e_lv) begin
                chk("ls_rob_id", 32'(ls_cdb_rob_id), 32'(e_l.id));
                chk("ls_result", ls_cdb_result, e_l.data);
            end
            chk("alu_ready", 32'(alu_ready), 32'(rdy && (aq.size() < D)));
            chk("bru_ready", 32'(bru_ready), 32'(rdy && (bq.size() < D)));
            chk("lsu_ready", 32'(lsu_ready), 32'(rdy));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 0; alu_rob_id = '0; alu_result = '0;
        bru_valid = 0; bru_rob_id = '0; bru_result = '0;
        lsu_valid = 0; lsu_rob_id = '0; lsu_result = '0;
    endtask

    task automatic do_reset();
        rst = 0; flush = 0; rdy = 1; idle();
        step();
        rst = 1;
        for (int t = 0; t < 16; t++) seen[t] = 0;
    endtask

    // ALU offers 1..7, BRU 8..14, each held until accepted; rdy dropped
    // for three cycles starting at stall_at (negative = never).
    task automatic burst(input int stall_at);
        int  ai = 0, bi = 0, cyc = 0;
        bit  a_take, b_take;
        while ((ai < 7 || bi < 7) && cyc < 200) begin
            rdy        = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 3);
            alu_valid  = (ai < 7);
            alu_rob_id = RW'(1 + ai);
            alu_result = 32'hA000_0000 + 32'(ai);
            bru_valid  = (bi < 7);
            bru_rob_id = RW'(8 + bi);
            bru_result = 32'hB000_0000 + 32'(bi);
            #1;
            a_take = alu_valid && alu_ready;
            b_take = bru_valid && bru_ready;
            step();
            if (a_take) ai++;
            if (b_take) bi++;
            cyc++;
        end
        if (ai < 7 || bi < 7) chk("burst_budget", 32'(ai + bi), 32'd14);
        rdy = 1;
        idle();
        for (int k = 0; k < 16; k++) step();
        for (int t = 1; t <= 14; t++) chk($sformatf("once_tag%0d", t), 32'(seen[t]), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 0; flush = 0; rdy = 1; idle();
        step(); step();
        chk("rst_arith_valid", 32'(arith_cdb_valid), 32'd0);
        chk("rst_arith_id", 32'(arith_cdb_rob_id), 32'd0);
        chk("rst_arith_res", arith_cdb_result, 32'd0);
        chk("rst_ls_valid", 32'(ls_cdb_valid), 32'd0);
        chk("rst_ls_id", 32'(ls_cdb_rob_id), 32'd0);
        chk("rst_ls_res", ls_cdb_result, 32'd0);
        rst = 1;

        // single ALU result: one-cycle pulse at N+1
        alu_valid = 1; alu_rob_id = 4'd5; alu_result = 32'hDEAD_BEEF;
        step(); idle();
        chk("t1_valid", 32'(arith_cdb_valid), 32'd1);
        chk("t1_id", 32'(arith_cdb_rob_id), 32'd5);
        chk("t1_res", arith_cdb_result, 32'hDEAD_BEEF);
        step();
        chk("t1_pulse_end", 32'(arith_cdb_valid), 32'd0);

        // first conflict after reset goes to ALU
        do_reset();
        alu_valid = 1; alu_rob_id = 4'd3; alu_result = 32'h0000_0333;
        bru_valid = 1; bru_rob_id = 4'd4; bru_result = 32'h0000_0444;
        step(); idle();
        chk("t2_first_id", 32'(arith_cdb_rob_id), 32'd3);
        chk("t2_bru_ready", 32'(bru_ready), 32'd1);
        step();
        chk("t2_second_valid", 32'(arith_cdb_valid), 32'd1);
        chk("t2_second_id", 32'(arith_cdb_rob_id), 32'd4);
        chk("t2_second_res", arith_cdb_result, 32'h0000_0444);
        step();
        chk("t2_idle", 32'(arith_cdb_valid), 32'd0);

        // sustained contention
        do_reset();
        burst(-1);

        // same burst with a 3-cycle rdy stall in the middle
        do_reset();
        burst(3);

        // flush with two entries pending per source
        do_reset();
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1; alu_rob_id = RW'(1 + i); alu_result = 32'hC000_0000 + 32'(i);
            bru_valid = 1; bru_rob_id = RW'(5 + i); bru_result = 32'hD000_0000 + 32'(i);
            step();
        end
        chk("t4_pre_id", 32'(arith_cdb_rob_id), 32'd6);
        flush = 1;
        alu_rob_id = 4'd11; bru_rob_id = 4'd12;
        step();
        flush = 0; idle();
        chk("t4_flush_valid", 32'(arith_cdb_valid), 32'd0);
        chk("t4_flush_ls", 32'(ls_cdb_valid), 32'd0);
        chk("t4_alu_ready", 32'(alu_ready), 32'd1);
        chk("t4_bru_ready", 32'(bru_ready), 32'd1);
        alu_valid = 1; alu_rob_id = 4'd2; alu_result = 32'h0000_2222;
        step(); idle();
        chk("t4_new_valid", 32'(arith_cdb_valid), 32'd1);
        chk("t4_new_id", 32'(arith_cdb_rob_id), 32'd2);
        for (int k = 0; k < 8; k++) step();
        chk("t4_seen3", 32'(seen[3]), 32'd0);
        chk("t4_seen4", 32'(seen[4]), 32'd0);
        chk("t4_seen7", 32'(seen[7]), 32'd0);
        chk("t4_seen8", 32'(seen[8]), 32'd0);
        chk("t4_seen11", 32'(seen[11]), 32'd0);
        chk("t4_seen12", 32'(seen[12]), 32'd0);
        chk("t4_seen2", 32'(seen[2]), 32'd2);

        // tag 0 is never broadcast
        alu_valid = 1; alu_rob_id = 4'd0; alu_result = 32'h1234;
        lsu_valid = 1; lsu_rob_id = 4'd0; lsu_result = 32'h5678;
        step(); idle();
        chk("zero_alu", 32'(arith_cdb_valid), 32'd0);
        chk("zero_lsu", 32'(ls_cdb_valid), 32'd0);

        // LS path, then reset right behind it
        lsu_valid = 1; lsu_rob_id = 4'd9; lsu_result = 32'h9999_0009;
        step(); idle();
        chk("ls_valid", 32'(ls_cdb_valid), 32'd1);
        chk("ls_id", 32'(ls_cdb_rob_id), 32'd9);
        chk("ls_res", ls_cdb_result, 32'h9999_0009);
        lsu_valid = 1; lsu_rob_id = 4'd9; lsu_result = 32'h9999_0009;
        rst = 0;
        step(); idle();
        chk("ls_rst_valid", 32'(ls_cdb_valid), 32'd0);
        chk("ls_rst_id", 32'(ls_cdb_rob_id), 32'd0);
        chk("ls_rst_res", ls_cdb_result, 32'd0);
        rst = 1;
        step();
        chk("ls_after_rst", 32'(ls_cdb_valid), 32'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
